// File: rtl/hs1way_rr_merger.sv
// Merges g_channels one-way push channels into one tagged output stream. Each channel has its own FIFO.
// Latency is 2 edges from push to output. There is no backpressure: a word pushed into a full FIFO is dropped and sets sticky p_overflow.
module hs1way_rr_merger #(
  parameter int g_data_size = 8,
  parameter int g_channels  = 4,
  parameter int g_depth     = 4,
  localparam int c_chan_w   = (g_channels > 1) ? $clog2(g_channels) : 1
) (
  input  logic                             p_clock,
  input  logic                             p_reset_n,
  input  logic [g_channels-1:0]            p_in_push,
  input  logic [g_channels*g_data_size-1:0] p_in_data,
  output logic                             p_out_push,
  output logic [g_data_size-1:0]           p_out_data,
  output logic [c_chan_w-1:0]              p_out_channel,
  output logic [g_channels-1:0]            p_overflow,
  input  logic                             p_clear_overflow
);

  localparam int c_ptr_w = $clog2(g_depth);

  logic [g_data_size-1:0] mem [g_channels][g_depth];
  logic [c_ptr_w-1:0]     rd_ptr [g_channels];
  logic [c_ptr_w-1:0]     wr_ptr [g_channels];
  logic [c_ptr_w:0]       cnt    [g_channels];

  logic [c_chan_w-1:0]    last_grant;
  logic [c_chan_w-1:0]    grant_idx;
  logic [c_chan_w-1:0]    cand;
  int                     cand_i;
  logic                   grant_vld;
  logic [g_data_size-1:0] grant_dat;
  logic [g_channels-1:0]  pop;
  logic [g_channels-1:0]  accept;
  logic [g_channels-1:0]  drop;

  // Candidates are judged on pre-edge counts, so a word written this edge waits one cycle.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_i    = 0;
    cand      = '0;
    for (int k = 1; k <= g_channels; k++) begin
      cand_i = (int'(last_grant) + k) % g_channels;
      cand   = c_chan_w'(cand_i);
      if (!grant_vld && (cnt[cand] != '0)) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_dat = mem[grant_idx][rd_ptr[grant_idx]];

  // A full FIFO still accepts a push when it is being popped at the same edge.
  always_comb begin
    pop    = '0;
    accept = '0;
    drop   = '0;
    for (int i = 0; i < g_channels; i++) begin
      pop[i]    = grant_vld && (grant_idx == c_chan_w'(i));
      accept[i] = p_in_push[i] && ((cnt[i] != (c_ptr_w+1)'(g_depth)) || pop[i]);
      drop[i]   = p_in_push[i] && (cnt[i] == (c_ptr_w+1)'(g_depth)) && !pop[i];
    end
  end

  always_ff @(posedge p_clock) begin
    for (int i = 0; i < g_channels; i++) begin
      if (accept[i]) begin
        mem[i][wr_ptr[i]] <= p_in_data[i*g_data_size +: g_data_size];
      end
    end
  end

  always_ff @(posedge p_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      for (int i = 0; i < g_channels; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      last_grant    <= c_chan_w'(g_channels - 1);
      p_out_push    <= 1'b0;
      p_out_data    <= '0;
      p_out_channel <= '0;
      p_overflow    <= '0;
    end else begin
      for (int i = 0; i < g_channels; i++) begin
        if (accept[i]) wr_ptr[i] <= wr_ptr[i] + c_ptr_w'(1);
        if (pop[i])    rd_ptr[i] <= rd_ptr[i] + c_ptr_w'(1);
        cnt[i]        <= cnt[i] + {c_ptr_w'(0), accept[i]} - {c_ptr_w'(0), pop[i]};
        p_overflow[i] <= drop[i] | (p_overflow[i] & ~p_clear_overflow);
      end
      p_out_push <= grant_vld;
      if (grant_vld) begin
        last_grant    <= grant_idx;
        p_out_data    <= grant_dat;
        p_out_channel <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_hs1way_rr_merger.sv
// Directed bench for hs1way_rr_merger with 4 channels, depth 4, and 8-bit data. Expected values are hand-derived.
module tb_hs1way_rr_merger;

  logic        p_clock = 1'b0;
  logic        p_reset_n;
  logic [3:0]  p_in_push;
  logic [31:0] p_in_data;
  logic        p_out_push;
  logic [7:0]  p_out_data;
  logic [1:0]  p_out_channel;
  logic [3:0]  p_overflow;
  logic        p_clear_overflow;

  int vectors     = 0;
  int miscompares = 0;

  always #5 p_clock = ~p_clock;

  hs1way_rr_merger #(
    .g_data_size(8),
    .g_channels (4),
    .g_depth    (4)
  ) dut (
    .p_clock         (p_clock),
    .p_reset_n       (p_reset_n),
    .p_in_push       (p_in_push),
    .p_in_data       (p_in_data),
    .p_out_push      (p_out_push),
    .p_out_data      (p_out_data),
    .p_out_channel   (p_out_channel),
    .p_overflow      (p_overflow),
    .p_clear_overflow(p_clear_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge p_clock);
    #1;
  endtask

  task automatic idle;
    p_in_push        = '0;
    p_in_data        = '0;
    p_clear_overflow = 1'b0;
  endtask

  task automatic put(input int ch, input logic [7:0] d);
    p_in_push[ch]       = 1'b1;
    p_in_data[ch*8 +: 8] = d;
  endtask

  task automatic do_reset;
    idle();
    p_reset_n = 1'b0;
    tick();
    tick();
    p_reset_n = 1'b1;
  endtask

  logic [7:0] rr_d   [5]  = '{8'h10, 8'h20, 8'h30, 8'h11, 8'h31};
  logic [1:0] rr_c   [5]  = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd3};
  logic [7:0] full_d [14] = '{8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13, 8'h04,
                              8'h14, 8'h05, 8'h15, 8'h06, 8'h16, 8'h07, 8'h77};
  logic [1:0] full_c [14] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0,
                              2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0};

  initial begin
    idle();
    p_reset_n = 1'b0;
    tick();
    tick();
    chk("rst_push", p_out_push, 0);
    chk("rst_data", p_out_data, 0);
    chk("rst_chan", p_out_channel, 0);
    chk("rst_ovf",  p_overflow, 0);
    p_reset_n = 1'b1;

    // Single word on channel 2
    put(2, 8'hA5);
    tick();
    chk("single_e1_push", p_out_push, 0);
    idle();
    tick();
    chk("single_e2_push", p_out_push, 1);
    chk("single_e2_data", p_out_data, 8'hA5);
    chk("single_e2_chan", p_out_channel, 2);
    tick();
    chk("single_e3_push", p_out_push, 0);
    chk("single_hold_data", p_out_data, 8'hA5);
    chk("single_hold_chan", p_out_channel, 2);

    // Round-robin ordering after a fresh reset
    do_reset();
    chk("rr_rst_data", p_out_data, 0);
    chk("rr_rst_chan", p_out_channel, 0);
    put(0, 8'h10);
    put(1, 8'h20);
    put(3, 8'h30);
    tick();
    chk("rr_e1_push", p_out_push, 0);
    idle();
    put(0, 8'h11);
    put(3, 8'h31);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      chk($sformatf("rr_push_%0d", i), p_out_push, 1);
      chk($sformatf("rr_data_%0d", i), p_out_data, rr_d[i]);
      chk($sformatf("rr_chan_%0d", i), p_out_channel, rr_c[i]);
    end
    tick();
    chk("rr_done_push", p_out_push, 0);

    // Overflow on ch1 while ch0, ch2, and ch3 push every cycle
    for (int e = 1; e <= 6; e++) begin
      idle();
      put(0, 8'(8'hA0 + e));
      put(1, 8'(e - 1));
      put(2, 8'(8'hB0 + e));
      put(3, 8'(8'hC0 + e));
      tick();
      if (e == 3) begin
        chk("ovf_e3_data", p_out_data, 8'h00);
        chk("ovf_e3_chan", p_out_channel, 1);
      end
      if (e < 6) chk($sformatf("ovf_e%0d_flags", e), p_overflow, 4'b0000);
      else       chk("ovf_e6_flags", p_overflow, 4'b1110);
    end
    idle();
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("drain_push_%0d", k), p_out_push, 1);
      chk($sformatf("drain_chan_%0d", k), p_out_channel, (1 + k) % 4);
      if (((1 + k) % 4) == 1) chk($sformatf("drain_ch1_data_%0d", k), p_out_data, (k / 4) + 1);
    end
    tick();
    chk("drain_done_push", p_out_push, 0);
    chk("drain_ovf_sticky", p_overflow, 4'b1110);

    // Clear coinciding with a ch3 drop, then a clear alone
    for (int e = 1; e <= 10; e++) begin
      idle();
      if (e <= 6) put(0, 8'(8'hD0 + e));
      if (e <= 9) put(3, 8'(8'hE0 + e));
      if (e >= 9) p_clear_overflow = 1'b1;
      tick();
      if (e == 8) begin
        chk("clr_e8_flags", p_overflow, 4'b1110);
        chk("clr_e8_data", p_out_data, 8'hE4);
        chk("clr_e8_chan", p_out_channel, 3);
      end
      if (e == 9)  chk("clr_set_wins", p_overflow, 4'b1000);
      if (e == 10) chk("clr_alone", p_overflow, 4'b0000);
    end
    idle();

    // Full ch0 accepts 0x77 on the edge it is popped
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      idle();
      if (e <= 7) put(0, 8'(e));
      if (e <= 6) put(1, 8'(8'h10 + e));
      if (e == 8) put(0, 8'h77);
      tick();
      if (e >= 2 && e <= 15) begin
        chk($sformatf("full_push_%0d", e), p_out_push, 1);
        chk($sformatf("full_data_%0d", e), p_out_data, full_d[e-2]);
        chk($sformatf("full_chan_%0d", e), p_out_channel, full_c[e-2]);
      end
      if (e == 8)  chk("full_pop_ovf", p_overflow, 4'b0000);
      if (e == 16) chk("full_done_push", p_out_push, 0);
    end
    idle();

    // Asynchronous reset while words are queued
    put(0, 8'h61);
    put(1, 8'h62);
    put(2, 8'h63);
    put(3, 8'h64);
    tick();
    idle();
    tick();
    chk("mid_pre_push", p_out_push, 1);
    chk("mid_pre_data", p_out_data, 8'h62);
    chk("mid_pre_chan", p_out_channel, 1);
    #2 p_reset_n = 1'b0;
    #1;
    chk("mid_rst_push", p_out_push, 0);
    chk("mid_rst_data", p_out_data, 0);
    chk("mid_rst_chan", p_out_channel, 0);
    chk("mid_rst_ovf",  p_overflow, 0);
    #2 p_reset_n = 1'b1;
    put(1, 8'h5A);
    put(3, 8'h3C);
    tick();
    chk("post_e1_push", p_out_push, 0);
    idle();
    tick();
    chk("post_e2_push", p_out_push, 1);
    chk("post_e2_data", p_out_data, 8'h5A);
    chk("post_e2_chan", p_out_channel, 1);
    tick();
    chk("post_e3_data", p_out_data, 8'h3C);
    chk("post_e3_chan", p_out_channel, 3);
    tick();
    chk("post_done_push", p_out_push, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
